// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: sizing, entry id format,
// instruction type encodings and the per-entry payload record.
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_POS_W = $clog2(ROB_SIZE);
  localparam int ROB_ID_W  = ROB_POS_W + 1;

  localparam logic [ROB_POS_W:0] ROB_FULL_CNT = ROB_ID_W'(ROB_SIZE);

  typedef logic [ROB_POS_W-1:0] rob_pos_t;

  // Rename tag seen by the register file: {rename_flag, pos}
  typedef struct packed {
    logic     rename_flag;
    rob_pos_t pos;
  } rob_id_t;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_EXIT   = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e   kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred_jump;
    logic        real_jump;
    logic [31:0] val;
    logic [31:0] target_pc;
  } rob_entry_t;

  function automatic rob_pos_t next_pos(input rob_pos_t pos);
    return pos + rob_pos_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / query / broadcast / commit signal bundle of the reorder buffer.
// The master side is the surrounding core; the slave side is the buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        rob_full;
  logic        issue;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred_jump;
  rob_pos_t    issue_rob_pos;

  rob_pos_t    qry1_pos;
  logic        qry1_ready;
  logic [31:0] qry1_val;
  rob_pos_t    qry2_pos;
  logic        qry2_ready;
  logic [31:0] qry2_val;

  logic        alu_valid;
  rob_pos_t    alu_rob_pos;
  logic [31:0] alu_val;
  logic        alu_real_jump;
  logic [31:0] alu_target_pc;
  logic        lsb_valid;
  rob_pos_t    lsb_rob_pos;
  logic [31:0] lsb_val;

  logic        commit_reg;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  rob_pos_t    commit_rob_pos;
  logic        commit_store;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        halt;

  modport master (
    output issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
    output qry1_pos, qry2_pos,
    output alu_valid, alu_rob_pos, alu_val, alu_real_jump, alu_target_pc,
    output lsb_valid, lsb_rob_pos, lsb_val,
    input  rob_full, issue_rob_pos,
    input  qry1_ready, qry1_val, qry2_ready, qry2_val,
    input  commit_reg, commit_rd, commit_val, commit_rob_pos,
    input  commit_store, rollback, rollback_pc, halt
  );

  modport slave (
    input  issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
    input  qry1_pos, qry2_pos,
    input  alu_valid, alu_rob_pos, alu_val, alu_real_jump, alu_target_pc,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    output rob_full, issue_rob_pos,
    output qry1_ready, qry1_val, qry2_ready, qry2_val,
    output commit_reg, commit_rd, commit_val, commit_rob_pos,
    output commit_store, rollback, rollback_pc, halt
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures ALU/LSB
// results, retires one entry per cycle from head and triggers rollback.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  reorder_buffer_if.slave bus
);

  rob_pos_t            head;
  rob_pos_t            tail;
  logic [ROB_POS_W:0]  count;
  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  rob_entry_t          entry [ROB_SIZE];

  rob_entry_t head_e;
  logic       can_retire;
  logic       mispredict;
  logic       flush;
  logic       do_issue;
  logic       alu_wr;
  logic       lsb_wr;

  assign head_e            = entry[head];
  assign bus.rob_full      = (count == ROB_FULL_CNT);
  assign bus.issue_rob_pos = tail;

  // A mispredict retire and the following rollback-pulse cycle both flush,
  // so wrong-path issue/writeback arriving in either cycle is discarded.
  assign can_retire = !bus.halt && busy[head] && ready[head];
  assign mispredict = can_retire && (head_e.kind == TYPE_BRANCH) &&
                      (head_e.real_jump != head_e.pred_jump);
  assign flush      = mispredict || bus.rollback;
  assign do_issue   = bus.issue && !bus.rob_full && !flush;
  assign alu_wr     = bus.alu_valid && busy[bus.alu_rob_pos] && !flush;
  assign lsb_wr     = bus.lsb_valid && busy[bus.lsb_rob_pos] && !flush;

  always_comb begin
    bus.qry1_ready = ready[bus.qry1_pos];
    bus.qry1_val   = entry[bus.qry1_pos].val;
    if (bus.alu_valid && (bus.alu_rob_pos == bus.qry1_pos)) begin
      bus.qry1_ready = 1'b1;
      bus.qry1_val   = bus.alu_val;
    end else if (bus.lsb_valid && (bus.lsb_rob_pos == bus.qry1_pos)) begin
      bus.qry1_ready = 1'b1;
      bus.qry1_val   = bus.lsb_val;
    end
  end

  always_comb begin
    bus.qry2_ready = ready[bus.qry2_pos];
    bus.qry2_val   = entry[bus.qry2_pos].val;
    if (bus.alu_valid && (bus.alu_rob_pos == bus.qry2_pos)) begin
      bus.qry2_ready = 1'b1;
      bus.qry2_val   = bus.alu_val;
    end else if (bus.lsb_valid && (bus.lsb_rob_pos == bus.qry2_pos)) begin
      bus.qry2_ready = 1'b1;
      bus.qry2_val   = bus.lsb_val;
    end
  end

  // Control state and registered commit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      busy               <= '0;
      ready              <= '0;
      bus.commit_reg     <= 1'b0;
      bus.commit_store   <= 1'b0;
      bus.rollback       <= 1'b0;
      bus.halt           <= 1'b0;
      bus.commit_rd      <= '0;
      bus.commit_val     <= '0;
      bus.commit_rob_pos <= '0;
      bus.rollback_pc    <= '0;
    end else begin
      bus.commit_reg   <= 1'b0;
      bus.commit_store <= 1'b0;
      bus.rollback     <= 1'b0;
      if (rdy) begin
        if (flush) begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
          busy  <= '0;
          ready <= '0;
          if (mispredict) begin
            bus.rollback    <= 1'b1;
            bus.rollback_pc <= head_e.real_jump ? head_e.target_pc
                                                : head_e.pc + 32'd4;
          end
        end else begin
          if (lsb_wr) ready[bus.lsb_rob_pos] <= 1'b1;
          if (alu_wr) ready[bus.alu_rob_pos] <= 1'b1;
          if (do_issue) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= 1'b0;
            tail        <= next_pos(tail);
          end
          if (can_retire) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= next_pos(head);
            case (head_e.kind)
              TYPE_REG: begin
                bus.commit_reg     <= 1'b1;
                bus.commit_rd      <= head_e.rd;
                bus.commit_val     <= head_e.val;
                bus.commit_rob_pos <= head;
              end
              TYPE_STORE: bus.commit_store <= 1'b1;
              TYPE_EXIT:  bus.halt         <= 1'b1;
              default: ;
            endcase
          end
          count <= count + ROB_ID_W'(do_issue) - ROB_ID_W'(can_retire);
        end
      end
    end
  end

  // Entry payload; validity is carried by busy/ready, so no reset here
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_issue) begin
        entry[tail] <= '{kind:      rob_type_e'(bus.issue_type),
                         rd:        bus.issue_rd,
                         pc:        bus.issue_pc,
                         pred_jump: bus.issue_pred_jump,
                         real_jump: 1'b0,
                         val:       '0,
                         target_pc: '0};
      end
      if (lsb_wr) entry[bus.lsb_rob_pos].val <= bus.lsb_val;
      if (alu_wr) begin
        entry[bus.alu_rob_pos].val       <= bus.alu_val;
        entry[bus.alu_rob_pos].real_jump <= bus.alu_real_jump;
        entry[bus.alu_rob_pos].target_pc <= bus.alu_target_pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all
// checked against a program-order queue model of the retirement rules.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic rst;
  logic rdy;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          pos;
    int          kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    bit          pred;
    bit          done;
    logic [31:0] val;
    bit          real_j;
    logic [31:0] tgt;
  } ment_t;

  ment_t       q[$];
  int          mtail;
  bit          m_halt;
  bit          e_creg, e_cst, e_rb;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_rbpc;
  int          e_pos;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rdy                 = 1'b1;
    bus.issue           = 1'b0;
    bus.issue_type      = 2'd0;
    bus.issue_rd        = 5'd0;
    bus.issue_pc        = 32'd0;
    bus.issue_pred_jump = 1'b0;
    bus.qry1_pos        = '0;
    bus.qry2_pos        = '0;
    bus.alu_valid       = 1'b0;
    bus.alu_rob_pos     = '0;
    bus.alu_val         = 32'd0;
    bus.alu_real_jump   = 1'b0;
    bus.alu_target_pc   = 32'd0;
    bus.lsb_valid       = 1'b0;
    bus.lsb_rob_pos     = '0;
    bus.lsb_val         = 32'd0;
  endtask

  task automatic model_reset();
    q.delete();
    mtail  = 0;
    m_halt = 0;
    e_creg = 0; e_cst = 0; e_rb = 0;
    e_rd = '0; e_val = '0; e_rbpc = '0; e_pos = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_clock();
    bit    full, retire, flush;
    ment_t h, n;
    full   = (q.size() == ROB_SIZE);
    flush  = e_rb;
    e_creg = 0; e_cst = 0; e_rb = 0;
    if (!rdy) return;
    retire = !m_halt && (q.size() > 0) && q[0].done;
    if (retire) begin
      h = q[0];
      case (h.kind)
        0: begin e_creg = 1; e_rd = h.rd; e_val = h.val; e_pos = h.pos; end
        1: e_cst = 1;
        3: m_halt = 1;
        default: if (h.real_j != h.pred) begin
          e_rb   = 1;
          e_rbpc = h.real_j ? h.tgt : h.pc + 32'd4;
          flush  = 1;
        end
      endcase
      void'(q.pop_front());
    end
    if (flush) begin
      q.delete();
      mtail = 0;
      return;
    end
    if (bus.lsb_valid)
      foreach (q[i]) if (q[i].pos == int'(bus.lsb_rob_pos)) begin
        q[i].done = 1; q[i].val = bus.lsb_val;
      end
    if (bus.alu_valid)
      foreach (q[i]) if (q[i].pos == int'(bus.alu_rob_pos)) begin
        q[i].done = 1; q[i].val = bus.alu_val;
        q[i].real_j = bus.alu_real_jump; q[i].tgt = bus.alu_target_pc;
      end
    if (bus.issue && !full) begin
      n.pos = mtail; n.kind = int'(bus.issue_type); n.rd = bus.issue_rd;
      n.pc = bus.issue_pc; n.pred = bus.issue_pred_jump; n.done = 0;
      n.val = '0; n.real_j = 0; n.tgt = '0;
      q.push_back(n);
      mtail = (mtail + 1) % ROB_SIZE;
    end
  endtask

  task automatic chk_qry(input string tag, input int pos, input logic r, input logic [31:0] v);
    bit          er = 0;
    logic [31:0] ev = '0;
    foreach (q[i]) if (q[i].pos == pos && q[i].done) begin er = 1; ev = q[i].val; end
    if (bus.lsb_valid && int'(bus.lsb_rob_pos) == pos) begin er = 1; ev = bus.lsb_val; end
    if (bus.alu_valid && int'(bus.alu_rob_pos) == pos) begin er = 1; ev = bus.alu_val; end
    chk({tag, "_ready"}, 32'(r), 32'(er));
    if (er) chk({tag, "_val"}, v, ev);
  endtask

  task automatic check_comb();
    chk("rob_full", 32'(bus.rob_full), 32'(q.size() == ROB_SIZE));
    chk("issue_rob_pos", 32'(bus.issue_rob_pos), 32'(mtail));
    chk_qry("qry1", int'(bus.qry1_pos), bus.qry1_ready, bus.qry1_val);
    chk_qry("qry2", int'(bus.qry2_pos), bus.qry2_ready, bus.qry2_val);
  endtask

  task automatic check_regs();
    chk("commit_reg", 32'(bus.commit_reg), 32'(e_creg));
    chk("commit_store", 32'(bus.commit_store), 32'(e_cst));
    chk("rollback", 32'(bus.rollback), 32'(e_rb));
    chk("halt", 32'(bus.halt), 32'(m_halt));
    chk("count", 32'(dut.count), 32'(q.size()));
    if (e_creg) begin
      chk("commit_rd", 32'(bus.commit_rd), 32'(e_rd));
      chk("commit_val", bus.commit_val, e_val);
      chk("commit_rob_pos", 32'(bus.commit_rob_pos), 32'(e_pos));
    end
    if (e_rb) chk("rollback_pc", bus.rollback_pc, e_rbpc);
  endtask

  task automatic cycle();
    #1;
    check_comb();
    model_clock();
    @(posedge clk);
    #1;
    check_regs();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_regs();
    chk("rst_commit_rd", 32'(bus.commit_rd), 32'd0);
    chk("rst_commit_val", bus.commit_val, 32'd0);
    chk("rst_commit_rob_pos", 32'(bus.commit_rob_pos), 32'd0);
    chk("rst_rollback_pc", bus.rollback_pc, 32'd0);
    chk("rst_issue_rob_pos", 32'(bus.issue_rob_pos), 32'd0);
  endtask

  task automatic issue_op(input int t, input int rd, input logic [31:0] pc, input bit pred);
    bus.issue           = 1'b1;
    bus.issue_type      = 2'(t);
    bus.issue_rd        = 5'(rd);
    bus.issue_pc        = pc;
    bus.issue_pred_jump = pred;
    cycle();
  endtask

  task automatic alu_wb(input int pos, input logic [31:0] v, input bit rj, input logic [31:0] tgt);
    bus.alu_valid     = 1'b1;
    bus.alu_rob_pos   = rob_pos_t'(pos);
    bus.alu_val       = v;
    bus.alu_real_jump = rj;
    bus.alu_target_pc = tgt;
    cycle();
  endtask

  initial begin
    int cand[$];
    int k;
    rst = 1'b1;
    idle();

    // In-order commit of out-of-order writebacks
    do_reset();
    issue_op(0, 1, 32'h0, 0);
    issue_op(0, 2, 32'h4, 0);
    issue_op(0, 3, 32'h8, 0);
    alu_wb(2, 32'h30, 0, 32'h0);
    alu_wb(0, 32'h10, 0, 32'h0);
    alu_wb(1, 32'h20, 0, 32'h0);
    chk("t1_c0_reg", 32'(bus.commit_reg), 32'd1);
    chk("t1_c0_rd", 32'(bus.commit_rd), 32'd1);
    chk("t1_c0_val", bus.commit_val, 32'h10);
    chk("t1_c0_pos", 32'(bus.commit_rob_pos), 32'd0);
    cycle();
    chk("t1_c1_rd", 32'(bus.commit_rd), 32'd2);
    chk("t1_c1_val", bus.commit_val, 32'h20);
    chk("t1_c1_pos", 32'(bus.commit_rob_pos), 32'd1);
    cycle();
    chk("t1_c2_rd", 32'(bus.commit_rd), 32'd3);
    chk("t1_c2_val", bus.commit_val, 32'h30);
    chk("t1_c2_pos", 32'(bus.commit_rob_pos), 32'd2);
    cycle();
    chk("t1_idle_reg", 32'(bus.commit_reg), 32'd0);

    // Fill to 16, overflow issue ignored, one retire frees a slot
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) issue_op(0, i + 1, 32'(i * 4), 0);
    chk("t2_full", 32'(bus.rob_full), 32'd1);
    issue_op(0, 20, 32'h400, 0);
    chk("t2_tail_after_17th", 32'(bus.issue_rob_pos), 32'd0);
    chk("t2_count_16", 32'(dut.count), 32'd16);
    alu_wb(0, 32'h55, 0, 32'h0);
    cycle();
    chk("t2_count_15", 32'(dut.count), 32'd15);
    chk("t2_not_full", 32'(bus.rob_full), 32'd0);
    chk("t2_commit_pos", 32'(bus.commit_rob_pos), 32'd0);

    // Branch mispredict flushes younger ops
    do_reset();
    issue_op(2, 0, 32'h100, 0);
    issue_op(0, 5, 32'h104, 0);
    issue_op(0, 6, 32'h108, 0);
    bus.lsb_valid   = 1'b1;
    bus.lsb_rob_pos = rob_pos_t'(1);
    bus.lsb_val     = 32'h77;
    alu_wb(0, 32'h0, 1, 32'h200);
    cycle();
    chk("t3_rollback", 32'(bus.rollback), 32'd1);
    chk("t3_rollback_pc", bus.rollback_pc, 32'h200);
    bus.alu_valid   = 1'b1;
    bus.alu_rob_pos = rob_pos_t'(2);
    issue_op(0, 9, 32'h10c, 0);
    chk("t3_rollback_off", 32'(bus.rollback), 32'd0);
    chk("t3_count_0", 32'(dut.count), 32'd0);
    chk("t3_tail_0", 32'(bus.issue_rob_pos), 32'd0);
    cycle();
    chk("t3_no_commit_a", 32'(bus.commit_reg), 32'd0);
    cycle();
    chk("t3_no_commit_b", 32'(bus.commit_reg), 32'd0);

    // Wrap-around with issue overlapping retire
    for (int i = 0; i < 20; i++) begin
      issue_op(0, (i % 31) + 1, 32'(i * 4), 0);
      if (i > 0) begin
        chk("t4_commit_reg", 32'(bus.commit_reg), 32'd1);
        chk("t4_commit_pos", 32'(bus.commit_rob_pos), 32'((i - 1) % ROB_SIZE));
      end
      chk("t4_count", 32'(dut.count), 32'd1);
      alu_wb(i % ROB_SIZE, 32'(i * 3 + 1), 0, 32'h0);
    end
    cycle();
    chk("t4_last_pos", 32'(bus.commit_rob_pos), 32'd3);

    // Same-cycle query forwarding
    bus.qry1_pos    = rob_pos_t'(5);
    bus.alu_valid   = 1'b1;
    bus.alu_rob_pos = rob_pos_t'(5);
    bus.alu_val     = 32'hDEAD;
    bus.qry2_pos    = rob_pos_t'(9);
    bus.lsb_valid   = 1'b1;
    bus.lsb_rob_pos = rob_pos_t'(9);
    bus.lsb_val     = 32'hBEEF;
    #1;
    chk("t5_qry1_ready", 32'(bus.qry1_ready), 32'd1);
    chk("t5_qry1_val", bus.qry1_val, 32'hDEAD);
    chk("t5_qry2_ready", 32'(bus.qry2_ready), 32'd1);
    chk("t5_qry2_val", bus.qry2_val, 32'hBEEF);
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rdy                 = ($urandom_range(0, 9) != 0);
      bus.issue           = ($urandom_range(0, 2) != 0);
      bus.issue_type      = 2'($urandom_range(0, 2));
      bus.issue_rd        = 5'($urandom);
      bus.issue_pc        = $urandom & 32'hFFFF_FFFC;
      bus.issue_pred_jump = 1'($urandom);
      bus.qry1_pos        = rob_pos_t'($urandom);
      bus.qry2_pos        = rob_pos_t'($urandom);
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(q[i].pos);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, cand.size() - 1);
        bus.alu_valid     = 1'b1;
        bus.alu_rob_pos   = rob_pos_t'(cand[k]);
        bus.alu_val       = $urandom;
        bus.alu_real_jump = 1'($urandom);
        bus.alu_target_pc = $urandom & 32'hFFFF_FFFC;
        cand.delete(k);
      end
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, cand.size() - 1);
        bus.lsb_valid   = 1'b1;
        bus.lsb_rob_pos = rob_pos_t'(cand[k]);
        bus.lsb_val     = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.lsb_rob_pos = rob_pos_t'($urandom);
        bus.lsb_valid   = !(bus.alu_valid && bus.alu_rob_pos == bus.lsb_rob_pos);
        bus.lsb_val     = $urandom;
      end
      cycle();
    end

    // STORE release then EXIT halts retirement for good
    do_reset();
    issue_op(1, 0, 32'h0, 0);
    issue_op(3, 0, 32'h4, 0);
    issue_op(0, 7, 32'h8, 0);
    bus.lsb_valid   = 1'b1;
    bus.lsb_rob_pos = rob_pos_t'(0);
    bus.lsb_val     = 32'h1234;
    alu_wb(1, 32'h0, 0, 32'h0);
    alu_wb(2, 32'h99, 0, 32'h0);
    chk("t6_store", 32'(bus.commit_store), 32'd1);
    chk("t6_store_no_reg", 32'(bus.commit_reg), 32'd0);
    cycle();
    chk("t6_store_pulse_end", 32'(bus.commit_store), 32'd0);
    chk("t6_halt", 32'(bus.halt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t6_halt_sticky", 32'(bus.halt), 32'd1);
      chk("t6_no_commit", 32'(bus.commit_reg), 32'd0);
    end

    do_reset();
    chk("final_halt_cleared", 32'(bus.halt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core.
- Sits between decoder/issue and the register file.
- Allocates an entry per issued instruction and captures results from the ALU and LSB broadcast buses.
- Retires at most one instruction per cycle in program order: register writes go to the register file, stores are released to the LSB, and branch mispredicts trigger a full rollback.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_POS_W, 4, log2(ROB_SIZE); entry index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; all state frozen when low
- rob_full  out  1  high when count==ROB_SIZE (combinational)
- issue  in  1  allocate entry at tail this cycle
- issue_type  in  2  0=REG (writes rd), 1=STORE, 2=BRANCH, 3=EXIT
- issue_rd  in  5  destination register (REG only)
- issue_pc  in  32  instruction pc
- issue_pred_jump  in  1  predicted taken (BRANCH only)
- issue_rob_pos  out  ROB_POS_W  current tail index, used as the new entry id
- qry1_pos  in  ROB_POS_W  operand-1 producer entry
- qry1_ready  out  1  producer value available
- qry1_val  out  32  producer value
- qry2_pos  in  ROB_POS_W  operand-2 producer entry
- qry2_ready  out  1  producer value available
- qry2_val  out  32  producer value
- alu_valid  in  1  ALU result broadcast
- alu_rob_pos  in  ROB_POS_W  target entry
- alu_val  in  32  result
- alu_real_jump  in  1  resolved taken (branches)
- alu_target_pc  in  32  resolved target (branches)
- lsb_valid  in  1  LSB result broadcast (loads, store address ready)
- lsb_rob_pos  in  ROB_POS_W  target entry
- lsb_val  in  32  result
- commit_reg  out  1  one-cycle pulse: write regfile
- commit_rd  out  5  retired destination register
- commit_val  out  32  retired value
- commit_rob_pos  out  ROB_POS_W  retired entry id; regfile clears rename only if it matches
- commit_store  out  1  one-cycle pulse: LSB may perform the oldest store
- rollback  out  1  one-cycle pulse: flush all speculative state
- rollback_pc  out  32  fetch redirect pc
- halt  out  1  sticky; set when EXIT retires

Behaviour:
- Per entry: busy, ready, type, rd, pc, pred_jump, real_jump, val, target_pc.
- Reset:
  - head=tail=count=0; all busy/ready cleared.
  - Every registered output driven 0 (commit_reg, commit_store, rollback, halt, commit_rd/val/rob_pos, rollback_pc).
- rdy low: no state change; all pulse outputs deasserted.
- Issue:
  - Entry at tail loaded with busy=1, ready=0; tail<=tail+1, wrapping mod ROB_SIZE.
  - Issue while rob_full is ignored; upstream must not do it.
  - issue_rob_pos always equals tail.
- Writeback:
  - alu_valid or lsb_valid sets ready=1 and val on the addressed entry; ALU also records real_jump and target_pc.
  - The two buses may write different entries in the same cycle.
  - A writeback to a non-busy entry is ignored.
- Query (combinational):
  - ready = entry.ready, or a same-cycle ALU/LSB broadcast to that position; value forwarded from the bus.
  - ALU has priority over LSB if both match (never legal).
- Commit, evaluated when head entry busy && ready:
  - REG: commit_reg=1, with rd/val/rob_pos registered next cycle.
  - STORE: commit_store=1.
  - EXIT: halt<=1; commits stop permanently.
  - BRANCH with real_jump==pred_jump: retires silently.
  - BRANCH with mismatch: rollback=1; rollback_pc = real_jump ? target_pc : pc+4.
- On any retire: head<=head+1 (wrap), entry busy cleared.
- Latency:
  - Issue to earliest commit: 2 cycles (issue, writeback, then retire next edge).
  - Commit outputs valid the cycle after the retire decision.
- Count:
  - +1 on issue, -1 on retire; simultaneous issue and retire leaves it unchanged.
  - Full and empty are tracked by count, not head==tail.
- Rollback cycle:
  - All entries cleared; head=tail=count=0.
  - Issue and writebacks presented in the same cycle are dropped.
  - Next cycle rollback deasserts and the buffer is empty.
- rst mid-operation overrides everything, including a pending rollback or commit.

Decomposition:
- Shared package/define file:
  - ROB_SIZE, ROB_POS_W.
  - ROB id format {rename_flag, pos}; width ROB_POS_W+1.
  - Type encodings TYPE_REG/STORE/BRANCH/EXIT.
- No sub-module needed.
- The entry array plus head/tail/count logic stays flat in reorder_buffer.

Test Plan:
- Reset, then issue three REG ops (rd=1,2,3); write back entries 2, 0, 1 via ALU with vals 0x30, 0x10, 0x20 -> commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles, commit_rob_pos 0, 1, 2.
- Issue 16 ops without writeback -> rob_full=1 after the 16th; a 17th issue is ignored, tail stays 0; one writeback plus retire drops count to 15.
- BRANCH at pc=0x100, pred_jump=0, ALU real_jump=1, target=0x200; two younger ops issued -> rollback pulse with rollback_pc=0x200, count=0 next cycle, no younger commits.
- Wrap-around: 20 issue/commit pairs -> tail and head wrap 15->0, commit_rob_pos sequence correct, count never exceeds 1.
- qry1_pos=5 while alu_valid, alu_rob_pos=5, alu_val=0xDEAD in the same cycle -> qry1_ready=1, qry1_val=0xDEAD.
- STORE retire -> commit_store pulses for one cycle with commit_reg=0; EXIT retire -> halt=1 and stays high, no further commits.
